fifo_read_packer: RTL and testbench

- Drain stage directly downstream of the 16-bit x 8 FIFO.
- Issues rd_en whenever the FIFO is non-empty and there is internal room.
- Captures each popped word one cycle after its read and packs PACK_COUNT words into one wide output beat.
- Output uses a valid/ready handshake. A flush request emits any partially packed beat. A FIFO underflow is latched as a sticky error.

---
 rtl/fifo_read_packer.sv | 106 ++++++++++
 tb/tb_fifo_read_packer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_packer.sv
// Drains a narrow FIFO and packs PACK_COUNT consecutive words into one wide
// valid/ready output beat, with flush of partial beats and a sticky underflow flag.
module fifo_read_packer #(
    parameter int FIFO_WIDTH = 16,
    parameter int PACK_COUNT = 2,
    parameter int OUT_WIDTH  = FIFO_WIDTH * PACK_COUNT,
    parameter int CNT_W      = $clog2(PACK_COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  busy,
    output logic                  err_underflow
);

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_cap;
    logic                 inflight;
    logic                 flush_pend;
    logic [OUT_WIDTH-1:0] pack_reg;
    logic [OUT_WIDTH-1:0] pack_cap;
    logic [CNT_W:0]       occupancy;
    logic                 slot_free;
    logic                 beat_full;
    logic                 flush_fire;
    logic                 flush_emit;

    // Words already captured plus the one still on its way from the FIFO.
    assign occupancy  = {1'b0, cnt} + {{CNT_W{1'b0}}, inflight};
    assign fifo_rd_en = rst_n && !fifo_empty && !flush_pend
                        && (occupancy < (CNT_W+1)'(PACK_COUNT));

    // Pack state as it would be after capturing this cycle's returning word.
    always_comb begin
        pack_cap = pack_reg;
        cnt_cap  = cnt;
        if (inflight) begin
            for (int i = 0; i < PACK_COUNT; i++) begin
                if (cnt == CNT_W'(i)) begin
                    pack_cap[i*FIFO_WIDTH +: FIFO_WIDTH] = fifo_data_out;
                end
            end
            cnt_cap = cnt + CNT_W'(1);
        end
    end

    assign slot_free  = !out_valid || out_ready;
    assign beat_full  = (cnt_cap == CNT_W'(PACK_COUNT)) && slot_free;
    assign flush_fire = flush_pend && !inflight && ((cnt == '0) || slot_free);
    assign flush_emit = flush_fire && (cnt != '0);

    assign busy = (cnt != '0) || inflight || flush_pend || out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            inflight      <= 1'b0;
            flush_pend    <= 1'b0;
            pack_reg      <= '0;
            out_data      <= '0;
            out_count     <= '0;
            out_valid     <= 1'b0;
            flush_done    <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            inflight   <= fifo_rd_en;
            cnt        <= cnt_cap;
            pack_reg   <= pack_cap;

            if (fifo_underflow) begin
                err_underflow <= 1'b1;
            end

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // A new beat may load on the same edge the previous one is consumed.
            if (beat_full || flush_emit) begin
                out_data  <= pack_cap;
                out_count <= cnt_cap;
                out_valid <= 1'b1;
                cnt       <= '0;
                pack_reg  <= '0;
            end

            if (flush_fire) begin
                flush_pend <= 1'b0;
                flush_done <= 1'b1;
            end else if (flush && !flush_pend) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Randomized bench for fifo_read_packer: a queue-based FIFO feeds the DUT and a
// word-order model predicts every output beat, including flushed partial beats.
module tb_fifo_read_packer;

    localparam int FW = 16;
    localparam int PC = 2;
    localparam int OW = FW * PC;
    localparam int CW = $clog2(PC + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [FW-1:0] fifo_data_out;
    logic          fifo_empty;
    logic          fifo_underflow;
    logic          fifo_rd_en;
    logic [OW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready;
    logic          flush;
    logic          flush_done;
    logic          busy;
    logic          err_underflow;

    fifo_read_packer #(.FIFO_WIDTH(FW), .PACK_COUNT(PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en),
        .out_data(out_data), .out_count(out_count), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush), .flush_done(flush_done),
        .busy(busy), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] data;
        logic [CW-1:0] count;
    } beat_t;

    int            tests_run = 0;
    int            tests_failed = 0;
    int            hs_count = 0;
    logic [FW-1:0] fq[$];
    logic [FW-1:0] grp[$];
    beat_t         expq[$];
    logic          rd_at_neg = 1'b0;
    bit            uf_exp = 0;
    bit            wait_flush = 0;
    bit            flush_seen = 0;
    bit            flush_beat_exp = 0;
    bit            holding = 0;
    logic [OW-1:0] held_data;
    logic [CW-1:0] held_count;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Words are concatenated in pop order, first word in the low bits.
    function automatic beat_t makeBeat();
        beat_t b;
        b.data = '0;
        for (int i = 0; i < grp.size(); i++) begin
            b.data |= OW'(grp[i]) << (i * FW);
        end
        b.count = CW'(grp.size());
        grp.delete();
        return b;
    endfunction

    task automatic resetModel();
        grp.delete();
        expq.delete();
        uf_exp = 0;
        wait_flush = 0;
        flush_beat_exp = 0;
    endtask

    always @(negedge clk) begin
        beat_t e;
        rd_at_neg = fifo_rd_en;
        if (!rst_n) begin
            holding = 0;
        end else begin
            checkOutput("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
            checkOutput("err_underflow", err_underflow, uf_exp);
            checkOutput("busy_with_valid", !busy & out_valid, 0);
            if (holding) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", out_data, held_data);
                checkOutput("hold_count", out_count, held_count);
            end
            if (wait_flush) begin
                if (flush_done) begin
                    flush_seen = 1;
                    wait_flush = 0;
                    if (flush_beat_exp) checkOutput("flush_beat_with_done", out_valid, 1);
                end else begin
                    checkOutput("rd_en_during_flush", fifo_rd_en, 0);
                end
            end else begin
                checkOutput("flush_done_unexpected", flush_done, 0);
            end
            if (out_valid && out_ready) begin
                hs_count++;
                checkOutput("beat_available", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    checkOutput("beat_data", out_data, e.data);
                    checkOutput("beat_count", out_count, e.count);
                end
            end
            holding    = out_valid && !out_ready;
            held_data  = out_data;
            held_count = out_count;
        end
    end

    // Advance one cycle: account for what the DUT did at the edge, then drive new inputs.
    task automatic applyStimulus(input int n_push, input logic ready, input logic do_flush, input logic uf);
        logic [FW-1:0] w;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (fifo_underflow) uf_exp = 1;
            if (rd_at_neg && fq.size() != 0) begin
                w = fq.pop_front();
                fifo_data_out = w;
                grp.push_back(w);
                if (grp.size() == PC) expq.push_back(makeBeat());
            end
            if (flush) begin
                flush_beat_exp = (grp.size() != 0);
                if (flush_beat_exp) expq.push_back(makeBeat());
                wait_flush = 1;
            end
        end
        for (int i = 0; i < n_push; i++) fq.push_back(FW'($urandom));
        out_ready      = ready;
        flush          = do_flush;
        fifo_underflow = uf;
        fifo_empty     = (fq.size() == 0);
    endtask

    task automatic doFlush(input bit rand_ready);
        flush_seen = 0;
        applyStimulus(0, rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100 && !flush_seen; i++) begin
            applyStimulus(0, rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1, 1'b0, 1'b0);
        end
        checkOutput("flush_done_seen", flush_seen, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic exp_rd[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int   hs0;

        rst_n = 1'b0;
        fifo_data_out = '0;
        fifo_empty = 1'b1;
        fifo_underflow = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        #12;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_count", out_count, 0);
        checkOutput("reset_flush_done", flush_done, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_err", err_underflow, 0);

        // Preloaded FIFO, consumer always ready: read pattern 1,1,0,1,1 then idle.
        fq.push_back(16'h1111); fq.push_back(16'h2222);
        fq.push_back(16'h3333); fq.push_back(16'h4444);
        fifo_empty = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("reset_rd_en_gated", fifo_rd_en, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hs0 = hs_count;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("rd_pattern", fifo_rd_en, exp_rd[i]);
            applyStimulus(0, 1'b1, 1'b0, 1'b0);
        end
        repeat (4) applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("preload_beats", hs_count - hs0, 2);

        // Backpressure: first beat held, second packed and stalled, then drained back-to-back.
        hs0 = hs_count;
        applyStimulus(6, 1'b0, 1'b0, 1'b0);
        repeat (8) applyStimulus(0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_valid_held", out_valid, 1);
        checkOutput("bp_rd_stalled", fifo_rd_en, 0);
        checkOutput("bp_no_handshake", hs_count - hs0, 0);
        checkOutput("bp_busy", busy, 1);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_first_drain", hs_count - hs0, 1);
        checkOutput("bp_second_valid", out_valid, 1);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_second_drain", hs_count - hs0, 2);
        repeat (10) applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_all_delivered", expq.size(), 0);

        // Flush of a single captured word.
        fq.push_back(16'hABCD);
        fifo_empty = 1'b0;
        repeat (3) applyStimulus(0, 1'b1, 1'b0, 1'b0);
        doFlush(0);
        repeat (3) applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_partial_delivered", expq.size(), 0);

        // Flush with nothing packed.
        hs0 = hs_count;
        doFlush(0);
        checkOutput("empty_flush_no_beat", out_valid, 0);
        checkOutput("empty_flush_no_handshake", hs_count - hs0, 0);

        // Underflow pulse latches the sticky error; packing continues.
        applyStimulus(0, 1'b1, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("err_underflow_set", err_underflow, 1);
        applyStimulus(4, 1'b1, 1'b0, 1'b0);
        repeat (8) applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("err_underflow_sticky", err_underflow, 1);

        // Reset with one word captured and another in flight.
        hs0 = hs_count;
        applyStimulus(4, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_out_data", out_data, 0);
        checkOutput("midreset_out_count", out_count, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_err", err_underflow, 0);
        checkOutput("midreset_rd_en", fifo_rd_en, 0);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (8) applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_one_beat", hs_count - hs0, 1);

        // Randomized traffic with backpressure, occasional flushes and underflow pulses.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 39) == 0) begin
                doFlush(1);
            end else begin
                applyStimulus((fq.size() < 8 && $urandom_range(0, 1) == 1) ? 1 : 0,
                              $urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 99) == 0);
            end
        end
        for (int i = 0; i < 200 && (fq.size() != 0 || expq.size() != 0 || grp.size() >= PC); i++) begin
            applyStimulus(0, 1'b1, 1'b0, 1'b0);
        end
        doFlush(0);
        repeat (5) applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("final_all_delivered", expq.size(), 0);
        checkOutput("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
